// File: rtl/motion_pkg.sv
// motion_pkg: shared types and default dimensions for the motion centroid path.
package motion_pkg;

  // Controller sequencing: idle, divide X sum, divide Y sum, publish result
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_X   = 2'd1,
    DIV_Y   = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  localparam int H_ACT_DEF = 320;
  localparam int V_ACT_DEF = 240;
  localparam int SUM_W_DEF = 32;
  localparam int CNT_W_DEF = 18;
  localparam int COORD_W   = 10;

endpackage

// File: rtl/motion_serial_div.sv
// motion_serial_div: restoring unsigned divider, one quotient bit per cycle.
// A start pulse loads the operands; exactly SUM_W cycles later 'done' is high
// for one cycle and 'quotient' carries the finished result in that same cycle.
// A start arriving together with 'done' begins the next division immediately.
module motion_serial_div
  import motion_pkg::*;
#(
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [SUM_W-1:0] divisor,
  output logic [SUM_W-1:0] quotient,
  output logic             done
);

  localparam int CW = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] r_rem;
  logic [SUM_W-1:0] r_quo;
  logic [SUM_W-1:0] r_div;
  logic [CW-1:0]    r_count;
  logic             r_active;

  logic [SUM_W:0]   w_trial;
  logic             w_ge;
  logic [SUM_W-1:0] w_rem_next;
  logic [SUM_W-1:0] w_quo_next;

  // Shift in the next dividend bit and try subtracting the divisor.
  // The remainder stays below the divisor, so the difference fits SUM_W bits.
  assign w_trial    = {r_rem, r_quo[SUM_W-1]};
  assign w_ge       = (w_trial >= {1'b0, r_div});
  assign w_rem_next = w_ge ? (w_trial[SUM_W-1:0] - r_div) : w_trial[SUM_W-1:0];
  assign w_quo_next = {r_quo[SUM_W-2:0], w_ge};

  assign done     = r_active && (r_count == CW'(1));
  assign quotient = w_quo_next;

  // Operand load on start, otherwise one restoring step per cycle while active
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_rem    <= '0;
      r_quo    <= dividend;
      r_div    <= divisor;
      r_count  <= CW'(SUM_W);
      r_active <= 1'b1;
    end else if (r_active) begin
      r_rem   <= w_rem_next;
      r_quo   <= w_quo_next;
      r_count <= r_count - CW'(1);
      if (r_count == CW'(1)) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/motion_centroid_ctrl.sv
// motion_centroid_ctrl: per-frame centre of mass of motion pixels.
// Optional build macro COM_SMOOTH_EN: average each publish with the previous one.
module motion_centroid_ctrl
  import motion_pkg::*;
#(
  parameter int H_ACT     = H_ACT_DEF,
  parameter int V_ACT     = V_ACT_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int MIN_COUNT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_tick,
  input  logic             DE,
  input  logic [9:0]       x_pixel,
  input  logic [9:0]       y_pixel,
  input  logic             motion_flag,
  output logic [9:0]       com_x,
  output logic [9:0]       com_y,
  output logic             com_valid,
  output logic             busy,
  output logic [CNT_W-1:0] motion_cnt,
  output logic             overrun
);

  // A zero threshold would allow a division by zero.
  if (MIN_COUNT < 1) begin : g_min_count_check
    $error("MIN_COUNT must be at least 1");
  end

  localparam logic [9:0] H_C = 10'(H_ACT);
  localparam logic [9:0] V_C = 10'(V_ACT);

  state_t r_state, w_state_next;

  logic [SUM_W-1:0] r_sum_x, r_sum_y, r_snap_y;
  logic [CNT_W-1:0] r_cnt, r_snap_cnt, r_motion_cnt;
  logic             r_fe_prev, r_overrun;
  logic [9:0]       r_quo_x, r_com_x, r_com_y;

  logic             w_in_win, w_fe_pos, w_frame_end, w_start_x, w_div_start, w_div_done;
  logic [SUM_W:0]   w_add_x, w_add_y;
  logic [CNT_W:0]   w_add_cnt;
  logic [SUM_W-1:0] w_dividend, w_divisor, w_quotient;
  logic [9:0]       w_pub_x, w_pub_y;

  assign w_in_win  = pix_tick & DE & motion_flag & (x_pixel < H_C) & (y_pixel < V_C);
  assign w_add_x   = {1'b0, r_sum_x} + (SUM_W+1)'(x_pixel);
  assign w_add_y   = {1'b0, r_sum_y} + (SUM_W+1)'(y_pixel);
  assign w_add_cnt = {1'b0, r_cnt} + (CNT_W+1)'(1);

  // Frame end is the first ticked cycle sitting on (H_ACT, V_ACT)
  assign w_fe_pos    = (x_pixel == H_C) && (y_pixel == V_C);
  assign w_frame_end = pix_tick & w_fe_pos & ~r_fe_prev;
  assign w_start_x   = w_frame_end && (r_state == IDLE) && (r_cnt >= CNT_W'(MIN_COUNT));

  // X starts straight from the live sums; Y starts from the snapshot as X finishes
  assign w_div_start = w_start_x | ((r_state == DIV_X) & w_div_done);
  assign w_dividend  = (r_state == IDLE) ? r_sum_x : r_snap_y;
  assign w_divisor   = (r_state == IDLE) ? SUM_W'(r_cnt) : SUM_W'(r_snap_cnt);

  motion_serial_div #(.SUM_W(SUM_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_div_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .quotient (w_quotient),
    .done     (w_div_done)
  );

  // Saturating accumulation of in-window motion pixels, cleared at frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (w_frame_end) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (w_in_win) begin
      r_sum_x <= w_add_x[SUM_W] ? '1 : w_add_x[SUM_W-1:0];
      r_sum_y <= w_add_y[SUM_W] ? '1 : w_add_y[SUM_W-1:0];
      r_cnt   <= w_add_cnt[CNT_W] ? '1 : w_add_cnt[CNT_W-1:0];
    end
  end

  // Frame-end edge tracking, per-frame count and overrun strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fe_prev    <= 1'b0;
      r_motion_cnt <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (pix_tick) r_fe_prev <= w_fe_pos;
      if (w_frame_end) r_motion_cnt <= r_cnt;
      r_overrun <= w_frame_end & busy;
    end
  end

  // Snapshot operands for Y only when a division is launched, so a late
  // frame end never disturbs the division in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap_y   <= '0;
      r_snap_cnt <= '0;
      r_quo_x    <= '0;
    end else begin
      if (w_start_x) begin
        r_snap_y   <= r_sum_y;
        r_snap_cnt <= r_cnt;
      end
      if ((r_state == DIV_X) && w_div_done) r_quo_x <= w_quotient[9:0];
    end
  end

`ifdef COM_SMOOTH_EN
  logic        r_have_prev;
  logic [10:0] w_avg_x, w_avg_y;
  logic        w_unused_bits;

  assign w_avg_x = {1'b0, r_com_x} + {1'b0, r_quo_x};
  assign w_avg_y = {1'b0, r_com_y} + {1'b0, w_quotient[9:0]};
  assign w_pub_x = r_have_prev ? w_avg_x[10:1] : r_quo_x;
  assign w_pub_y = r_have_prev ? w_avg_y[10:1] : w_quotient[9:0];
  assign w_unused_bits = ^{w_quotient[SUM_W-1:10], w_avg_x[0], w_avg_y[0]};

  // First publish after reset loads directly; later ones average
  always_ff @(posedge clk) begin
    if (reset) r_have_prev <= 1'b0;
    else if ((r_state == DIV_Y) && w_div_done) r_have_prev <= 1'b1;
  end
`else
  logic w_unused_bits;

  assign w_pub_x = r_quo_x;
  assign w_pub_y = w_quotient[9:0];
  assign w_unused_bits = ^w_quotient[SUM_W-1:10];
`endif

  // Centroid outputs load as the Y division completes, visible in PUBLISH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_com_x <= '0;
      r_com_y <= '0;
    end else if ((r_state == DIV_Y) && w_div_done) begin
      r_com_x <= w_pub_x;
      r_com_y <= w_pub_y;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    com_valid    = 1'b0;
    case (r_state)
      IDLE:    if (w_start_x) w_state_next = DIV_X;
      DIV_X: begin
        busy = 1'b1;
        if (w_div_done) w_state_next = DIV_Y;
      end
      DIV_Y: begin
        busy = 1'b1;
        if (w_div_done) w_state_next = PUBLISH;
      end
      PUBLISH: begin
        com_valid    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign com_x      = r_com_x;
  assign com_y      = r_com_y;
  assign motion_cnt = r_motion_cnt;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_motion_centroid_ctrl.sv
// Bench for motion_centroid_ctrl: two instances (MIN_COUNT 1 and 4) share the
// pixel stream; expected publishes are queued at frame end and a monitor pops
// and compares them whenever com_valid is seen.
module tb_motion_centroid_ctrl;

  logic       clk = 1'b0;
  logic       reset, pix_tick, DE, motion_flag;
  logic [9:0] x_pixel, y_pixel;

  logic [9:0]  com_x_a, com_y_a, com_x_b, com_y_b;
  logic        com_valid_a, busy_a, overrun_a, com_valid_b, busy_b, overrun_b;
  logic [17:0] motion_cnt_a, motion_cnt_b;

  motion_centroid_ctrl #(.MIN_COUNT(1)) dut_a (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .motion_flag(motion_flag),
    .com_x(com_x_a), .com_y(com_y_a), .com_valid(com_valid_a), .busy(busy_a),
    .motion_cnt(motion_cnt_a), .overrun(overrun_a)
  );

  motion_centroid_ctrl #(.MIN_COUNT(4)) dut_b (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .DE(DE),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .motion_flag(motion_flag),
    .com_x(com_x_b), .com_y(com_y_b), .com_valid(com_valid_b), .busy(busy_b),
    .motion_cnt(motion_cnt_b), .overrun(overrun_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_a   = 0;
  int ovr_b   = 0;

  typedef struct {
    int t;
    int qx;
    int qy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   prev_x[2];
  int   prev_y[2];
  bit   have_prev[2];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void mon(int w, logic [9:0] cx, logic [9:0] cy);
    exp_t  e;
    int    ex, ey;
    string tag;
    tag = (w == 0) ? "a" : "b";
    if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected_valid: got com=(%0d,%0d) at cycle %0d, expected no publish", tag, cx, cy, cyc);
      return;
    end
    e  = (w == 0) ? qa.pop_front() : qb.pop_front();
    ex = e.qx;
    ey = e.qy;
`ifdef COM_SMOOTH_EN
    if (have_prev[w]) begin
      ex = (prev_x[w] + e.qx) >> 1;
      ey = (prev_y[w] + e.qy) >> 1;
    end
`endif
    prev_x[w]    = ex;
    prev_y[w]    = ey;
    have_prev[w] = 1'b1;
    check({tag, "_pub_cycle"}, cyc, e.t + 65);
    check({tag, "_com_x"}, cx, ex);
    check({tag, "_com_y"}, cy, ey);
    $display("[TB] %s publish cycle %0d com=(%0d,%0d)", tag, cyc, cx, cy);
  endfunction

  // Monitor: compares every publish against the queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (com_valid_a) mon(0, com_x_a, com_y_a);
      if (com_valid_b) mon(1, com_x_b, com_y_b);
      if (overrun_a) ovr_a++;
      if (overrun_b) ovr_b++;
    end
  end

  task automatic drive(input logic tk, input logic de, input int x, input int y, input logic fl);
    @(posedge clk);
    #1;
    pix_tick    = tk;
    DE          = de;
    x_pixel     = 10'(x);
    y_pixel     = 10'(y);
    motion_flag = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic pix(input int x, input int y);
    drive(1'b1, 1'b1, x, y, 1'b1);
  endtask

  // Frame end held three cycles with DE and motion high; returns cycle T
  task automatic frame_end(input bit pa, input bit pb, input int qx, input int qy,
                           input int cnt, output int t);
    exp_t e;
    drive(1'b1, 1'b1, 320, 240, 1'b1);
    t    = cyc;
    e.t  = t;
    e.qx = qx;
    e.qy = qy;
    if (pa) qa.push_back(e);
    if (pb) qb.push_back(e);
    drive(1'b1, 1'b1, 320, 240, 1'b1);
    drive(1'b1, 1'b1, 320, 240, 1'b1);
    idle(1);
    check("a_motion_cnt", motion_cnt_a, cnt);
    check("b_motion_cnt", motion_cnt_b, cnt);
    $display("[TB] frame end at cycle %0d, expected cnt %0d, publish a=%0d b=%0d", t, cnt, pa, pb);
  endtask

  int t;

  initial begin
    reset = 1'b1; pix_tick = 1'b0; DE = 1'b0; motion_flag = 1'b0;
    x_pixel = '0; y_pixel = '0;
    have_prev = '{1'b0, 1'b0};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    check("rst_com_x", com_x_a, 0);
    check("rst_com_y", com_y_a, 0);
    check("rst_valid", com_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_motion_cnt", motion_cnt_a, 0);
    check("rst_overrun", overrun_a, 0);

    // One pixel plus rejected pixels (outside window, DE low, tick low)
    pix(100, 50);
    pix(320, 5);
    pix(5, 240);
    drive(1'b1, 1'b0, 7, 7, 1'b1);
    drive(1'b0, 1'b1, 9, 9, 1'b1);
    frame_end(1, 0, 100, 50, 1, t);
    idle(5);
    check("a_busy_div", busy_a, 1);
    check("b_busy_idle", busy_b, 0);
    idle(70);

    // Empty frame: nothing published, result held
    frame_end(0, 0, 0, 0, 0, t);
    idle(70);
    check("a_hold_x", com_x_a, 100);
    check("a_hold_y", com_y_a, 50);

    pix(10, 20);
    pix(13, 25);
    frame_end(1, 0, 11, 22, 2, t);
    idle(70);

    // Window edge pixels
    pix(319, 239);
    pix(1, 1);
    frame_end(1, 0, 160, 120, 2, t);
    idle(70);

    // Below and at the higher threshold
    repeat (3) pix(8, 8);
    frame_end(1, 0, 8, 8, 3, t);
    idle(70);
    check("b_below_min_x", com_x_b, 0);
    repeat (4) pix(8, 8);
    frame_end(1, 1, 8, 8, 4, t);
    idle(70);

    // Pixel tick one cycle in four, coordinates held
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 30 + 20 * i, 40 + 20 * i, 1'b1);
      repeat (3) drive(1'b0, 1'b1, 30 + 20 * i, 40 + 20 * i, 1'b1);
    end
    frame_end(1, 1, 60, 70, 4, t);
    idle(70);

    // Overrun: second frame end at T+10 of the division
    pix(200, 150);
    pix(202, 150);
    pix(204, 152);
    pix(206, 156);
    frame_end(1, 1, 203, 152, 4, t);
    pix(1, 1);
    while (cyc < t + 9) idle(1);
    drive(1'b1, 1'b0, 320, 240, 1'b0);
    check("a_busy_at_overrun", busy_a, 1);
    idle(1);
    check("a_overrun_cnt", motion_cnt_a, 1);
    idle(70);
    check("a_overrun_pulses", ovr_a, 1);
    check("b_overrun_pulses", ovr_b, 1);

    // Reset at T+20 abandons the division
    repeat (4) pix(5, 5);
    frame_end(0, 0, 0, 0, 4, t);
    while (cyc < t + 19) idle(1);
    @(posedge clk);
    #1 reset = 1'b1;
    have_prev = '{1'b0, 1'b0};
    @(posedge clk);
    #1 reset = 1'b0;
    check("rst2_com_x", com_x_a, 0);
    check("rst2_com_y", com_y_a, 0);
    check("rst2_busy", busy_a, 0);
    check("rst2_motion_cnt", motion_cnt_a, 0);
    check("rst2_b_com_x", com_x_b, 0);
    idle(70);
    check("rst2_no_publish_x", com_x_a, 0);

    check("a_pending_publishes", qa.size(), 0);
    check("b_pending_publishes", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_centroid_ctrl.md
# motion_centroid_ctrl

Frame-level controller for the motion centre-of-mass path. Accumulates the coordinates of motion-flagged pixels inside the camera window, and at frame end snapshots the sums. It then runs a shared serial divider twice (X, then Y) and publishes `com_x`/`com_y` with a one-cycle valid strobe. It sits between the frame-compare stage (source of `motion_flag`) and the motion display overlay, and replaces any single-cycle division in the pixel path.

## Interface
- `H_ACT`, 320: window width; pixels with `x_pixel < H_ACT` accumulate.
- `V_ACT`, 240: window height; pixels with `y_pixel < V_ACT` accumulate.
- `SUM_W`, 32: width of the sum accumulators and of the divider.
- `CNT_W`, 18: width of the motion pixel counter.
- `MIN_COUNT`, 1: minimum motion pixels per frame needed to publish.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `pix_tick` in 1: one pixel per asserted cycle; tie high when `clk` is the pixel clock.
- `DE` in 1: VGA display enable.
- `x_pixel` in 10: current pixel column.
- `y_pixel` in 10: current pixel row.
- `motion_flag` in 1: current pixel shows motion.
- `com_x` out 10: published centroid X.
- `com_y` out 10: published centroid Y.
- `com_valid` out 1: one-cycle pulse when `com_x`/`com_y` update.
- `busy` out 1: high while a division is in progress.
- `motion_cnt` out CNT_W: motion pixel count of the last completed frame.
- `overrun` out 1: one-cycle pulse when a frame end arrives while `busy`.

## Operation
- **Accumulate (always active, independent of FSM).**
  - Condition: `pix_tick & DE & x_pixel<H_ACT & y_pixel<V_ACT & motion_flag`.
  - Action: `sum_x += x_pixel`, `sum_y += y_pixel`, `cnt += 1`.
  - The adds saturate at all-ones.
- **Frame-end event.** Rising edge of `(x_pixel==H_ACT && y_pixel==V_ACT)`, qualified by `pix_tick`. It fires exactly once per frame, even if the coordinates are held for several clocks.
- **On frame end:**
  - Snapshot `sum_x`, `sum_y` and `cnt`.
  - Load `motion_cnt` from `cnt`.
  - Clear the accumulators in the same cycle. The frame-end pixel lies outside the window, so it is never accumulated.
- **FSM states:**
  - IDLE → DIV_X when a frame end arrives and snapshot cnt ≥ MIN_COUNT. Otherwise stay in IDLE: no publish, `com_*` held.
  - DIV_X: divider computes snap_sum_x / snap_cnt over SUM_W cycles; quotient latched, then → DIV_Y.
  - DIV_Y: same computation for Y → PUBLISH.
  - PUBLISH: load `com_x`/`com_y` from the low 10 bits of the quotients (truncating division), assert `com_valid` → IDLE.
- **`busy`** is high in DIV_X and DIV_Y.
- **Frame end while busy:**
  - Accumulators are still snapshotted and cleared, and `motion_cnt` is updated.
  - The division in progress continues unaffected; the new frame is not divided.
  - `overrun` pulses.
- **Reset:**
  - Every register clears: `com_x`=0, `com_y`=0, `com_valid`=0, `busy`=0, `motion_cnt`=0, `overrun`=0, FSM=IDLE.
  - A division in progress is abandoned, with no publish.

## Timing
- Frame-end event in cycle T (registered at the end of T).
- DIV_X occupies T+1 … T+SUM_W.
- DIV_Y occupies T+SUM_W+1 … T+2·SUM_W.
- PUBLISH is cycle T+2·SUM_W+1; `com_*` change and `com_valid`=1 in that cycle. With the defaults this is T+65.
- `com_*` are otherwise stable for the whole frame.
- The divider is restoring, one quotient bit per cycle, and finishes in exactly SUM_W cycles.
- The divisor is never zero, because MIN_COUNT ≥ 1 is enforced by an elaboration-time assertion.

## Configuration
- `COM_SMOOTH_EN` defined:
  - The first publish after reset loads the quotients directly.
  - Each later publish loads (old + new) >> 1 per axis, computed in 11 bits and truncated.
  - Latency is unchanged.
- `COM_SMOOTH_EN` undefined: quotients are loaded directly on every publish.

## Structure
- Package `motion_pkg` holds:
  - the FSM state enum (`IDLE`, `DIV_X`, `DIV_Y`, `PUBLISH`);
  - default `H_ACT`/`V_ACT` constants;
  - default `SUM_W`/`CNT_W` localparams.
- Sub-module `motion_serial_div`:
  - Interface: `start`, `dividend[SUM_W]`, `divisor[SUM_W]` → `quotient[SUM_W]`, `done`.
  - A single instance is shared for X and Y.

## Test plan
- One motion pixel at (100,50), then frame end → `com_valid` at T+65 with `com`=(100,50); `motion_cnt`=1.
- Motion at (10,20) and (13,25) → sums (23,45), cnt 2 → `com`=(11,22).
- A frame with no motion after a frame published (100,50) → no `com_valid`, `com` stays (100,50), `motion_cnt`=0.
- MIN_COUNT=4 with 3 motion pixels → no publish; 4 pixels at (8,8) → `com`=(8,8).
- Frame end forced at T+10 of a division → `overrun` pulses once; the original result still publishes at T+65. Reset at T+20 of a division → all outputs 0, no `com_valid`.
- With `COM_SMOOTH_EN`: first frame (100,50) then second frame (200,150) → publishes (100,50), then (150,100). With `pix_tick` high one cycle in four, each pixel is counted once.
